// File: rtl/partition_splitter.sv
// Scatters one merged 2*PW x PH row-major region into two PW x PH partitions.
// Optional macro SPLITTER_RELU_EN clamps negative words to zero on the write path.
module partition_splitter #(
  parameter int unsigned PARTITION_WIDTH  = 5,
  parameter int unsigned PARTITION_HEIGHT = 5,
  parameter int unsigned DATA_WIDTH       = 27,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned ADDRESS_IN       = 0,
  parameter int unsigned ADDRESS_0_OUT    = 0,
  parameter int unsigned ADDRESS_1_OUT    = 25,
  parameter int unsigned READ_LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] read_address_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic [ADDR_WIDTH-1:0] write_address_out,
  output logic                  write_en_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned RowCols = 2 * PARTITION_WIDTH;
  localparam int unsigned ColW    = $clog2(RowCols);
  localparam int unsigned RowW    = (PARTITION_HEIGHT > 1) ? $clog2(PARTITION_HEIGHT) : 1;

  localparam logic [ColW-1:0]       ColLast  = ColW'(RowCols - 1);
  localparam logic [ColW-1:0]       ColSplit = ColW'(PARTITION_WIDTH);
  localparam logic [ColW-1:0]       ColOne   = ColW'(1);
  localparam logic [RowW-1:0]       RowLast  = RowW'(PARTITION_HEIGHT - 1);
  localparam logic [RowW-1:0]       RowOne   = RowW'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  issue;

  logic [ColW-1:0]       col_local;
  logic [ADDR_WIDTH-1:0] local_addr;
  logic [ADDR_WIDTH-1:0] dest;

  logic [READ_LATENCY:0] vld_q;
  logic [ADDR_WIDTH-1:0] dest_q [READ_LATENCY+1];

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] result_d;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rd_addr_d = rd_addr_q;
    issue     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d   = StRead;
          row_d     = '0;
          col_d     = '0;
          rd_addr_d = ADDR_WIDTH'(ADDRESS_IN);
          issue     = 1'b1;
        end
      end
      StRead: begin
        if (row_q == RowLast && col_q == ColLast) begin
          state_d = StDrain;
        end else begin
          // The merged region is contiguous, so the read address just steps by one.
          issue     = 1'b1;
          rd_addr_d = rd_addr_q + AddrOne;
          if (col_q == ColLast) begin
            col_d = '0;
            row_d = row_q + RowOne;
          end else begin
            col_d = col_q + ColOne;
          end
        end
      end
      StDrain: begin
        if (!(|vld_q)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Destination is derived from the counters of the read being issued this edge.
  always_comb begin
    col_local  = (col_d >= ColSplit) ? (col_d - ColSplit) : col_d;
    local_addr = ADDR_WIDTH'(row_d) * ADDR_WIDTH'(PARTITION_WIDTH) + ADDR_WIDTH'(col_local);
    dest       = ((col_d >= ColSplit) ? ADDR_WIDTH'(ADDRESS_1_OUT) : ADDR_WIDTH'(ADDRESS_0_OUT))
                 + local_addr;
  end

`ifdef SPLITTER_RELU_EN
  assign result_d = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
  assign result_d = data_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      rd_addr_q <= '0;
      vld_q     <= '0;
      for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
        dest_q[i] <= '0;
      end
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rd_addr_q <= rd_addr_d;
      // Stage 0 lines up with the registered read address; the last stage with data_in.
      vld_q     <= {vld_q[READ_LATENCY-1:0], issue};
      dest_q[0] <= dest;
      for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
        dest_q[i] <= dest_q[i-1];
      end
      wr_en_q <= vld_q[READ_LATENCY];
      if (vld_q[READ_LATENCY]) begin
        wr_addr_q <= dest_q[READ_LATENCY];
        result_q  <= result_d;
      end
    end
  end

  assign read_address_out  = rd_addr_q;
  assign write_en_out      = wr_en_q;
  assign write_address_out = wr_addr_q;
  assign result_out        = result_q;
  assign busy_out          = (state_q == StRead) || (state_q == StDrain);
  assign done_out          = (state_q == StDone);

endmodule

// File: tb/tb_partition_splitter.sv
// Self-checking bench for partition_splitter against a row/column reference model.
module tb_partition_splitter;

  localparam int PW = 5;
  localparam int PH = 5;
  localparam int DW = 27;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int N  = 2 * PW * PH;
  localparam int A_IN = 0;
  localparam int A_0  = 0;
  localparam int A_1  = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [DW-1:0] data_in;
  logic [AW-1:0] read_address_out;
  logic [DW-1:0] result_out;
  logic [AW-1:0] write_address_out;
  logic          write_en_out;
  logic          busy_out;
  logic          done_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem  [1024];
  logic [DW-1:0] dmem [1024];
  logic [DW-1:0] m1, m2;

  always #5 clk = ~clk;

  partition_splitter #(
    .PARTITION_WIDTH (PW),
    .PARTITION_HEIGHT(PH),
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .ADDRESS_IN      (A_IN),
    .ADDRESS_0_OUT   (A_0),
    .ADDRESS_1_OUT   (A_1),
    .READ_LATENCY    (RL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .data_in          (data_in),
    .read_address_out (read_address_out),
    .result_out       (result_out),
    .write_address_out(write_address_out),
    .write_en_out     (write_en_out),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  // Two-register-stage M10K model.
  always @(posedge clk) begin
    m1 <= mem[read_address_out];
    m2 <= m1;
  end
  assign data_in = m2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: merged index i -> (row, col) -> partition and local offset.
  function automatic logic [AW-1:0] exp_addr(input int i);
    int r, c;
    r = i / (2 * PW);
    c = i % (2 * PW);
    if (c >= PW) return AW'(A_1 + r * PW + (c - PW));
    return AW'(A_0 + r * PW + c);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int i);
    logic [DW-1:0] w;
    w = mem[A_IN + i];
`ifdef SPLITTER_RELU_EN
    if (w[DW-1]) w = '0;
`endif
    return w;
  endfunction

  task automatic img_check(input string name);
    for (int i = 0; i < N; i++) check_eq({name, "_img"}, dmem[exp_addr(i)], exp_data(i));
  endtask

  task automatic do_xfer(input string name, input int gap, input int repulse_at,
                         input int abort_at);
    int wcount, last_w, stray;
    bit finished;
    for (int k = 0; k < 1024; k++) dmem[k] = '0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wcount = 0;
    last_w = 0;
    finished = 1'b0;
    for (int n = 1; n <= 150 && !finished; n++) begin
      if (n == 1) begin
        check_eq({name, "_rd0"}, read_address_out, A_IN);
        check_eq({name, "_busy_start"}, busy_out, 1);
      end
      if (write_en_out) begin
        if (wcount == 0) check_eq({name, "_first_wr_cycle"}, n, RL + 2);
        else check_eq({name, "_wr_contig"}, n, last_w + 1);
        if (wcount < N) begin
          check_eq({name, "_wr_addr"}, write_address_out, exp_addr(wcount));
          check_eq({name, "_wr_data"}, result_out, exp_data(wcount));
          dmem[write_address_out] = result_out;
        end
        wcount++;
        last_w = n;
      end
      if (abort_at > 0 && n == abort_at + 1) begin
        check_eq({name, "_abort_wen"}, write_en_out, 0);
        check_eq({name, "_abort_busy"}, busy_out, 0);
        check_eq({name, "_abort_done"}, done_out, 0);
        check_eq({name, "_abort_rdaddr"}, read_address_out, 0);
        reset = 1'b0;
        finished = 1'b1;
      end else if (done_out) begin
        check_eq({name, "_done_gap"}, n, last_w + 1);
        check_eq({name, "_wr_count"}, wcount, N);
        check_eq({name, "_busy_at_done"}, busy_out, 0);
        run = 1'b1;  // offered in the DONE cycle; must not start a transfer
        @(negedge clk);
        run = 1'b0;
        check_eq({name, "_done_pulse_len"}, done_out, 0);
        check_eq({name, "_run_in_done_ignored"}, busy_out, 0);
        finished = 1'b1;
      end
      if (!finished) begin
        run   = (n == repulse_at);
        reset = (abort_at > 0 && n == abort_at);
        @(negedge clk);
      end
    end
    if (!finished) check_eq({name, "_timeout"}, 0, 1);
    if (abort_at > 0) begin
      stray = 0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (done_out || write_en_out || busy_out) stray++;
      end
      check_eq({name, "_quiet_after_abort"}, stray, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = DW'(a + 1);
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_wen", write_en_out, 0);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_done", done_out, 0);
    check_eq("rst_rdaddr", read_address_out, 0);
    check_eq("rst_wraddr", write_address_out, 0);
    check_eq("rst_result", result_out, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic transfer with a run glitch while busy.
    do_xfer("basic", 0, 10, 0);
    check_eq("route_idx5", dmem[25], 6);
    check_eq("route_idx10", dmem[5], 11);
    check_eq("route_idx49", dmem[49], 50);
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        check_eq("part0_word", dmem[A_0 + r * PW + c], r * 10 + c + 1);
        check_eq("part1_word", dmem[A_1 + r * PW + c], r * 10 + c + 6);
      end
    end

    // Back-to-back: run in the first IDLE cycle after DONE.
    do_xfer("second", 0, 0, 0);
    img_check("second");

    do_xfer("abort", 1, 0, 20);
    do_xfer("after_abort", 1, 0, 0);
    img_check("after_abort");

    mem[7] = 27'h7FFFFFD;
    do_xfer("relu", 2, 0, 0);
`ifdef SPLITTER_RELU_EN
    check_eq("neg_word_dest27", dmem[27], 0);
`else
    check_eq("neg_word_dest27", dmem[27], 27'h7FFFFFD);
`endif

    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < N; a++) mem[A_IN + a] = DW'($urandom);
      do_xfer("rand", int'($urandom_range(0, 5)), int'($urandom_range(2, 45)), 0);
      img_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/partition_splitter.md
Name: partition_splitter

Overview:
- Inverse of the Merger. Reads one merged row-major region of 2*PARTITION_WIDTH x PARTITION_HEIGHT words from M10K, starting at ADDRESS_IN.
- Scatters the region into two separate PARTITION_WIDTH x PARTITION_HEIGHT partitions at ADDRESS_0_OUT and ADDRESS_1_OUT.
- Sits between a layer's merged output buffer and the per-partition M10K banks feeding the next layer.
- Uses the same fixed-latency M10K read interface as the Merger: an address is issued and data returns READ_LATENCY cycles later.

Parameters:
- PARTITION_WIDTH, 5, columns per partition
- PARTITION_HEIGHT, 5, rows per partition
- DATA_WIDTH, 27, word width (signed two's complement)
- ADDR_WIDTH, 10, read/write address width
- ADDRESS_IN, 0, base read address of the merged region
- ADDRESS_0_OUT, 0, base write address of partition 0 (left half)
- ADDRESS_1_OUT, 25, base write address of partition 1 (right half)
- READ_LATENCY, 2, cycles from read_address_out to matching data_in; legal range 1..4

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- run  in  1  start pulse, sampled only in IDLE
- data_in  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after its address
- read_address_out  out  ADDR_WIDTH  registered read address
- result_out  out  DATA_WIDTH  write data
- write_address_out  out  ADDR_WIDTH  write address
- write_en_out  out  1  write strobe
- busy_out  out  1  high from the cycle after run is accepted until done_out
- done_out  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM to IDLE, counters and the delay line cleared. Reset asserted mid-operation aborts the transfer; write_en_out is 0 on the next cycle; no done_out pulse.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: run=1 at edge T0 moves to READ. Row/col counters set to 0; read_address_out=ADDRESS_IN in the cycle after T0.
- READ: one read issued per cycle. read_address_out = ADDRESS_IN + row*2*PW + col. col wraps at 2*PW-1 and increments row. After index 2*PW*PH-1 is issued, go to DRAIN.
- Destination address uses counters only (no divider):
  - p = (col >= PW)
  - local = row*PW + (col mod PW)
  - dest = (p ? ADDRESS_1_OUT : ADDRESS_0_OUT) + local
- Delay line: dest and a valid bit are delayed READ_LATENCY stages so they line up with data_in.
- Write outputs are registered. For a read issued in cycle k: write_en_out=1, write_address_out=dest, result_out=data_in in cycle k+READ_LATENCY+1.
- Write count: exactly 2*PW*PH strobes, contiguous with no bubbles.
- DRAIN: waits until the delay line is empty and the last write has been presented, then goes to DONE.
- DONE: done_out=1 for one cycle, busy_out drops the same cycle, then IDLE.
- run while busy is ignored. run in the DONE cycle is ignored. run in the first IDLE cycle after DONE is accepted.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No overflow detection.
- read_address_out holds its last value outside READ.

Optional Feature:
- Macro: SPLITTER_RELU_EN.
- Defined: result_out = 0 whenever the delayed data_in MSB is 1 (negative); otherwise data_in unchanged. Write addresses and timing are unchanged.
- Undefined: data passes unmodified.

Test Plan:
- Setup for all cases: memory model with 2 register stages, word at addr a = a+1, defaults; run pulse at T0.
  - Write order: read addr 0 at T0+1, first write at T0+4 with addr 0, data 1.
  - Partition routing: read index 5 -> write addr 25, data 6; index 10 -> addr 5, data 11; index 49 -> addr 49, data 50; 50 strobes total; done_out exactly one cycle after the last strobe.
- Full image check: after done, the destination model holds partition0[r*5+c]=r*10+c+1 and partition1[r*5+c]=r*10+c+6 for all r,c in 0..4.
- run re-pulsed at T0+10 -> ignored; still exactly 50 writes. A second run after done -> identical second transfer.
- reset asserted at T0+20 -> next cycle write_en_out=0, busy_out=0, no done_out. A following run -> a clean full 50-write transfer.
- SPLITTER_RELU_EN defined, word 7 set to -3 -> the write carrying index 7 (dest 27) has data 0. Undefined -> data -3 (27'h7FFFFFD).
